// File: rtl/mmio_timer_bank_pkg.sv
// Shared definitions for the MMIO timer bank: register offsets, prescaler
// select encoding and the channel control register layout.
package timer_defs;

  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_RELOAD_LO = 3'd1;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd2;
  localparam logic [2:0] OFF_COUNT_LO  = 3'd3;
  localparam logic [2:0] OFF_COUNT_HI  = 3'd4;

  localparam logic [5:0] ADDR_PEND = 6'h3E;
  localparam logic [5:0] ADDR_IEN  = 6'h3F;

  localparam logic [7:0] RD_UNMAPPED    = 8'hFF;
  localparam logic [7:0] CTRL_RW_MASK   = 8'h0F;
  localparam int         CTRL_FORCE_BIT = 7;

  typedef enum logic [1:0] {
    PSEL_DIV1   = 2'd0,
    PSEL_DIV16  = 2'd1,
    PSEL_DIV64  = 2'd2,
    PSEL_DIV256 = 2'd3
  } psel_e;

  // Force-reload is write-only, so the stored copy of that bit is always 0.
  typedef struct packed {
    logic       force_reload;
    logic [2:0] rsvd;
    psel_e      psel;
    logic       oneshot;
    logic       en;
  } ctrl_s;

endpackage

// File: rtl/mmio_timer_bank_channel.sv
// One down-counting timer channel: control, reload, count, and the high-byte
// shadow that makes a COUNT_LO-then-COUNT_HI read atomic.
module timer_channel_m
  import timer_defs::*;
#(
  parameter int CNT_W = 16
) (
  input  logic       clk_4mhz,
  input  logic       rst,
  input  logic [3:0] ticks,
  input  logic       wr,
  input  logic       rd,
  input  logic [2:0] off,
  input  logic [7:0] wdata,
  output logic [7:0] rd_byte,
  output logic       expire
);

  ctrl_s            ctrl;
  ctrl_s            wr_ctrl;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] reload;
  logic [7:0]       shadow;
  logic [15:0]      count_ext;
  logic [15:0]      reload_ext;
  logic [15:0]      reload_wr;
  logic             ctrl_wr;
  logic             reload_wr_en;
  logic             load_on_write;
  logic             tick;

  assign wr_ctrl       = ctrl_s'(wdata & CTRL_RW_MASK);
  assign ctrl_wr       = wr && (off == OFF_CTRL);
  assign reload_wr_en  = wr && ((off == OFF_RELOAD_LO) || (off == OFF_RELOAD_HI));
  assign load_on_write = (wr_ctrl.en && !ctrl.en) || wdata[CTRL_FORCE_BIT];
  assign tick          = ticks[ctrl.psel];
  assign count_ext     = 16'(count);
  assign reload_ext    = 16'(reload);

  // A CTRL write swallows a coincident tick, so it also suppresses expiry.
  assign expire = !rst && !ctrl_wr && tick && ctrl.en && (count == '0);

  always_comb begin
    reload_wr = reload_ext;
    if (off == OFF_RELOAD_LO) reload_wr[7:0] = wdata;
    else                      reload_wr[15:8] = wdata;
  end

  always_ff @(posedge clk_4mhz) begin
    if (rst) begin
      ctrl   <= '0;
      count  <= '0;
      reload <= '0;
      shadow <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= wr_ctrl;
        if (load_on_write) count <= reload;
      end else if (tick && ctrl.en) begin
        if (count == '0) begin
          count <= reload;
          if (ctrl.oneshot) ctrl.en <= 1'b0;
        end else begin
          count <= count - CNT_W'(1);
        end
      end
      // Bits of RELOAD_HI beyond CNT_W fall away in the truncation.
      if (reload_wr_en) reload <= reload_wr[CNT_W-1:0];
      if (rd && (off == OFF_COUNT_LO)) shadow <= count_ext[15:8];
    end
  end

  always_comb begin
    rd_byte = RD_UNMAPPED;
    case (off)
      OFF_CTRL:      rd_byte = 8'(ctrl);
      OFF_RELOAD_LO: rd_byte = reload_ext[7:0];
      OFF_RELOAD_HI: rd_byte = reload_ext[15:8];
      OFF_COUNT_LO:  rd_byte = count_ext[7:0];
      OFF_COUNT_HI:  rd_byte = shadow;
      default:       rd_byte = RD_UNMAPPED;
    endcase
  end

endmodule

// File: rtl/mmio_timer_bank.sv
// Bank of N_CH down-counting timers behind an 8-bit MMIO port, with a shared
// prescaler, pending/enable interrupt registers and a registered read mux.
module mmio_timer_bank
  import timer_defs::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic            clk_4mhz,
  input  logic            rst,
  input  logic [5:0]      addr,
  input  logic [7:0]      wdata,
  input  logic            we,
  input  logic            re,
  output logic [7:0]      rdata,
  output logic            irq,
  output logic [N_CH-1:0] expire
);

  logic [7:0]      prescaler;
  logic [3:0]      ticks;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] ien;
  logic [N_CH-1:0] pend_clr;
  logic [N_CH-1:0] chan_hit;
  logic [7:0]      rd_bytes [N_CH];
  logic [7:0]      rd_next;

  always_ff @(posedge clk_4mhz) begin
    if (rst) prescaler <= '0;
    else     prescaler <= prescaler + 8'd1;
  end

  assign ticks = {prescaler == 8'd0, prescaler[5:0] == 6'd0, prescaler[3:0] == 4'd0, 1'b1};

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign chan_hit[c] = (addr[5:3] == 3'(c)) && (addr[2:0] <= OFF_COUNT_HI);

    timer_channel_m #(.CNT_W(CNT_W)) u_ch (
      .clk_4mhz (clk_4mhz),
      .rst      (rst),
      .ticks    (ticks),
      .wr       (we && chan_hit[c]),
      .rd       (re && chan_hit[c]),
      .off      (addr[2:0]),
      .wdata    (wdata),
      .rd_byte  (rd_bytes[c]),
      .expire   (expire[c])
    );
  end

  // A new expiry outranks a same-cycle W1C of that bit.
  assign pend_clr = (we && (addr == ADDR_PEND)) ? wdata[N_CH-1:0] : '0;

  always_ff @(posedge clk_4mhz) begin
    if (rst) begin
      pend <= '0;
      ien  <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | expire;
      if (we && (addr == ADDR_IEN)) ien <= wdata[N_CH-1:0];
    end
  end

  assign irq = |(pend & ien);

  always_comb begin
    rd_next = RD_UNMAPPED;
    if (addr == ADDR_PEND)     rd_next = 8'(pend);
    else if (addr == ADDR_IEN) rd_next = 8'(ien);
    else begin
      for (int c = 0; c < N_CH; c++) begin
        if (chan_hit[c]) rd_next = rd_bytes[c];
      end
    end
  end

  always_ff @(posedge clk_4mhz) begin
    if (rst)     rdata <= RD_UNMAPPED;
    else if (re) rdata <= rd_next;
  end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Scoreboard bench: the driver steps a behavioural model and queues expected
// responses; a monitor compares expire/irq each cycle and rdata after each read.
module tb_mmio_timer_bank;

  localparam int NCH      = 4;
  localparam int CNT_MASK = 'hFFFF;

  logic           clk_4mhz = 1'b0;
  logic           rst = 1'b1;
  logic [5:0]     addr = '0;
  logic [7:0]     wdata = '0;
  logic           we = 1'b0;
  logic           re = 1'b0;
  logic [7:0]     rdata;
  logic           irq;
  logic [NCH-1:0] expire;

  logic [5:0] s_addr = '0;
  logic [7:0] s_wdata = '0;
  logic       s_we = 1'b0;
  logic       s_re = 1'b0;
  logic [7:0] s_rdata;
  logic       s_irq;
  logic [0:0] s_expire;

  int n_vec = 0;
  int n_err = 0;

  int   rd_q [$];
  logic [NCH-1:0] exp_q [$];
  bit   irq_q [$];

  int m_count [NCH];
  int m_reload [NCH];
  int m_shadow [NCH];
  int m_psel [NCH];
  bit m_en [NCH];
  bit m_oneshot [NCH];
  int m_pend, m_ien, m_presc;

  mmio_timer_bank #(.N_CH(NCH), .CNT_W(16)) u_dut (
    .clk_4mhz (clk_4mhz), .rst (rst), .addr (addr), .wdata (wdata),
    .we (we), .re (re), .rdata (rdata), .irq (irq), .expire (expire)
  );

  mmio_timer_bank #(.N_CH(1), .CNT_W(8)) u_dut_small (
    .clk_4mhz (clk_4mhz), .rst (rst), .addr (s_addr), .wdata (s_wdata),
    .we (s_we), .re (s_re), .rdata (s_rdata), .irq (s_irq), .expire (s_expire)
  );

  always #5 clk_4mhz = ~clk_4mhz;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pselDiv(input int p);
    case (p)
      0:       return 1;
      1:       return 16;
      2:       return 64;
      default: return 256;
    endcase
  endfunction

  function automatic int modelRead(input int a);
    int ch;
    int off;
    ch  = a / 8;
    off = a % 8;
    if (a == 'h3E) return m_pend;
    if (a == 'h3F) return m_ien;
    if (ch >= NCH || off > 4) return 'hFF;
    case (off)
      0:       return m_psel[ch] * 4 + int'(m_oneshot[ch]) * 2 + int'(m_en[ch]);
      1:       return m_reload[ch] % 256;
      2:       return m_reload[ch] / 256;
      3:       return m_count[ch] % 256;
      default: return m_shadow[ch];
    endcase
  endfunction

  task automatic resetModel();
    for (int c = 0; c < NCH; c++) begin
      m_count[c] = 0; m_reload[c] = 0; m_shadow[c] = 0;
      m_psel[c] = 0; m_en[c] = 0; m_oneshot[c] = 0;
    end
    m_pend = 0; m_ien = 0; m_presc = 0;
  endtask

  // Model of one clock: outputs from the current state, then the next state.
  task automatic modelStep();
    int expv;
    int clr;
    bit irqv;
    expv = 0;
    irqv = (m_pend & m_ien) != 0;
    if (re && !rst) rd_q.push_back(modelRead(int'(addr)));
    if (rst) begin
      resetModel();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        int  cnt0;
        int  base;
        bit  tick;
        bit  was_en;
        cnt0 = m_count[c];
        base = c * 8;
        tick = (m_presc % pselDiv(m_psel[c])) == 0;
        if (we && int'(addr) == base) begin
          was_en = m_en[c];
          m_en[c] = wdata[0];
          m_oneshot[c] = wdata[1];
          m_psel[c] = int'(wdata[3:2]);
          if ((wdata[0] && !was_en) || wdata[7]) m_count[c] = m_reload[c];
        end else if (tick && m_en[c]) begin
          if (cnt0 == 0) begin
            expv = expv | (1 << c);
            m_count[c] = m_reload[c];
            if (m_oneshot[c]) m_en[c] = 1'b0;
          end else begin
            m_count[c] = cnt0 - 1;
          end
        end
        if (re && int'(addr) == base + 3) m_shadow[c] = cnt0 / 256;
        if (we && int'(addr) == base + 1) m_reload[c] = (m_reload[c] & 'hFF00) | int'(wdata);
        if (we && int'(addr) == base + 2)
          m_reload[c] = ((m_reload[c] & 'hFF) | int'(wdata) * 256) & CNT_MASK;
      end
      clr = (we && addr == 6'h3E) ? (int'(wdata) & 'hF) : 0;
      m_pend = (m_pend & ~clr) | expv;
      if (we && addr == 6'h3F) m_ien = int'(wdata) & 'hF;
      m_presc = (m_presc + 1) % 256;
    end
    exp_q.push_back(NCH'(expv));
    irq_q.push_back(irqv);
  endtask

  task automatic applyStimulus(input logic rs, input logic w, input logic r,
                               input logic [5:0] a, input logic [7:0] d);
    @(negedge clk_4mhz);
    rst = rs; we = w; re = r; addr = a; wdata = d;
    modelStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [5:0] a);
    applyStimulus(1'b0, 1'b0, 1'b1, a, 8'h00);
  endtask

  bit re_prev = 1'b0;
  bit rst_prev = 1'b0;

  always @(negedge clk_4mhz) begin
    #2;
    if (rst_prev) checkOutput("rdata_after_reset", int'(rdata), 'hFF);
    if (re_prev) begin
      if (rd_q.size() == 0) checkOutput("rdata_unexpected", int'(rdata), -1);
      else checkOutput("rdata", int'(rdata), rd_q.pop_front());
    end
    if (exp_q.size() != 0) checkOutput("expire", int'(expire), int'(exp_q.pop_front()));
    if (irq_q.size() != 0) checkOutput("irq", int'(irq), int'(irq_q.pop_front()));
    re_prev  = re && !rst;
    rst_prev = rst;
  end

  task automatic smallWrite(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk_4mhz);
    s_we = 1'b1; s_addr = a; s_wdata = d;
    @(negedge clk_4mhz);
    s_we = 1'b0;
  endtask

  task automatic smallRead(input logic [5:0] a, output int d);
    @(negedge clk_4mhz);
    s_re = 1'b1; s_addr = a;
    @(negedge clk_4mhz);
    s_re = 1'b0;
    #1;
    d = int'(s_rdata);
  endtask

  initial begin
    int op;
    int ch;
    int t0;
    int t1;
    int v;
    logic [7:0] d;
    logic [5:0] base;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    for (int a = 0; a < 64; a++) rd(6'(a));

    // Periodic channel 0 with interrupt, then W1C and re-assertion.
    wr(6'h01, 8'h03); wr(6'h02, 8'h00); wr(6'h3F, 8'h01); wr(6'h00, 8'h01);
    idle(20);
    rd(6'h3E);
    wr(6'h3E, 8'h01);
    idle(12);

    // W1C hammered across expiries, and a force-reload on a tick cycle.
    repeat (8) wr(6'h3E, 8'h01);
    rd(6'h3E);
    wr(6'h00, 8'h81);
    rd(6'h03);

    // One-shot channel 1 at divide-by-16.
    wr(6'h09, 8'h02); wr(6'h0A, 8'h00); wr(6'h08, 8'h07);
    idle(48);
    rd(6'h08);
    idle(200);

    // Atomic LO/HI reads on channel 2 starting at the 0x0100 boundary.
    wr(6'h11, 8'h00); wr(6'h12, 8'h01); wr(6'h10, 8'h01);
    for (int j = 0; j < 6; j++) begin
      rd(6'h13);
      rd(6'h14);
      idle(int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 1500; i++) begin
      op   = int'($urandom_range(0, 9));
      ch   = int'($urandom_range(0, 4));
      base = 6'(ch * 8);
      d    = 8'($urandom_range(0, 255));
      if (i == 700 || i == 701) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
      end else begin
        case (op)
          0: begin
            d[3:2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            d[7]   = ($urandom_range(0, 3) == 0);
            d[0]   = ($urandom_range(0, 3) != 0);
            wr(base, d);
          end
          1: wr(base + 6'd1, d);
          2: wr(base + 6'd2, ($urandom_range(0, 3) == 0) ? d : 8'h00);
          3: rd(base + 6'($urandom_range(0, 7)));
          4: if (d[0]) rd(6'h3E); else wr(6'h3E, d);
          5: wr(6'h3F, d);
          6: if (d[1]) rd(6'($urandom_range(0, 63))); else wr(6'($urandom_range(0, 63)), d);
          default: idle(1);
        endcase
      end
    end
    idle(3);
    checkOutput("read_queue_drained", rd_q.size(), 0);

    // Narrow instance: one 8-bit channel.
    smallWrite(6'h02, 8'hFF);
    smallRead(6'h02, v);
    checkOutput("small_reload_hi_masked", v, 'h00);
    smallRead(6'h08, v);
    checkOutput("small_unmapped_channel", v, 'hFF);
    smallWrite(6'h01, 8'hFF);
    smallWrite(6'h00, 8'h01);
    t0 = -1;
    t1 = -1;
    for (int n = 0; n < 700; n++) begin
      @(posedge clk_4mhz);
      #1;
      if (s_expire[0]) begin
        if (t0 < 0) t0 = n;
        else if (t1 < 0) t1 = n;
      end
    end
    checkOutput("small_period_256", (t1 < 0) ? 0 : t1 - t0, 256);
    checkOutput("small_irq_masked", int'(s_irq), 0);
    smallRead(6'h3E, v);
    checkOutput("small_pend_set", v, 'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
